team_wb_gpio_ctrl: RTL

Parametrised Wishbone-slave GPIO controller, the next generation of the team project bus wrappers: it turns a team top level's fixed pin tie-offs into a software-visible register bank. It sits between the management core's Wishbone slave port and the caravel GPIO pads. It provides per-pin output, output-enable and synchronized input registers, a reserved-pin mask, and per-pin edge interrupts with write-1-to-clear status.

---
 rtl/team_wb_gpio_pkg.sv | 63 ++++++
 rtl/team_wb_gpio_ctrl_edge_sync.sv | 36 +++
 rtl/team_wb_gpio_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/team_wb_gpio_pkg.sv
// Shared register map, register index enum and byte-lane merge helpers
// for the Wishbone GPIO controller.
`timescale 1ns/1ps
package team_wb_gpio_pkg;

  localparam logic [31:0] WINDOW_SIZE = 32'd64;

  localparam logic [5:0] OFF_OUT_LO  = 6'h00;
  localparam logic [5:0] OFF_OUT_HI  = 6'h04;
  localparam logic [5:0] OFF_OEB_LO  = 6'h08;
  localparam logic [5:0] OFF_OEB_HI  = 6'h0C;
  localparam logic [5:0] OFF_IN_LO   = 6'h10;
  localparam logic [5:0] OFF_IN_HI   = 6'h14;
  localparam logic [5:0] OFF_EN_LO   = 6'h18;
  localparam logic [5:0] OFF_EN_HI   = 6'h1C;
  localparam logic [5:0] OFF_MODE_LO = 6'h20;
  localparam logic [5:0] OFF_MODE_HI = 6'h24;
  localparam logic [5:0] OFF_STAT_LO = 6'h28;
  localparam logic [5:0] OFF_STAT_HI = 6'h2C;
  localparam logic [5:0] OFF_ID      = 6'h30;

  // Word index within the window (offset bits 5:2)
  typedef enum logic [3:0] {
    REG_OUT_LO  = 4'd0,
    REG_OUT_HI  = 4'd1,
    REG_OEB_LO  = 4'd2,
    REG_OEB_HI  = 4'd3,
    REG_IN_LO   = 4'd4,
    REG_IN_HI   = 4'd5,
    REG_EN_LO   = 4'd6,
    REG_EN_HI   = 4'd7,
    REG_MODE_LO = 4'd8,
    REG_MODE_HI = 4'd9,
    REG_STAT_LO = 4'd10,
    REG_STAT_HI = 4'd11,
    REG_ID      = 4'd12
  } gpio_reg_e;

  // Replace only the byte lanes whose select bit is set
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int n = 0; n < 4; n++) begin
      if (sel[n]) res[8*n +: 8] = new_v[8*n +: 8];
    end
    return res;
  endfunction

  // Byte-merge into the LO or HI half of a 64-bit register
  function automatic logic [63:0] word_merge(input logic [63:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel,
                                             input logic        hi);
    logic [63:0] res;
    res = old_v;
    if (hi) res[63:32] = byte_merge(old_v[63:32], new_v, sel);
    else    res[31:0]  = byte_merge(old_v[31:0],  new_v, sel);
    return res;
  endfunction

endpackage

// File: rtl/team_wb_gpio_ctrl_edge_sync.sv
// Two-flop input synchronizer plus history flop; flags per-bit rising and
// falling edges of the synchronized value.
`timescale 1ns/1ps
module gpio_edge_sync #(
  parameter int WIDTH = 38
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] h;

  // Metastability chain followed by one cycle of history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      h  <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      h  <= s2;
    end
  end

  assign sync = s2;
  assign rise = s2 & ~h;
  assign fall = ~s2 & h;

endmodule

// File: rtl/team_wb_gpio_ctrl.sv
// Wishbone classic slave exposing GPIO output, output-enable, synchronized
// input and edge-interrupt registers; reserved pins are forced to input.
`timescale 1ns/1ps
module team_wb_gpio_ctrl
  import team_wb_gpio_pkg::*;
#(
  parameter int          NUM_GPIO      = 38,
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter logic [63:0] RESERVED_MASK = 64'h1E,
  parameter logic [31:0] ID_VALUE      = 32'h6770_0001
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] gpio_out,
  output logic [NUM_GPIO-1:0] gpio_oeb,
  output logic                irq_o
);

  // Bits that correspond to real pins; everything above reads 0
  localparam logic [63:0] PIN_MASK = (NUM_GPIO >= 64) ? {64{1'b1}}
                                   : ((64'd1 << NUM_GPIO) - 64'd1);
  localparam logic [63:0] RES_MASK = RESERVED_MASK & PIN_MASK;

  logic [31:0] off;
  logic        in_win;
  logic        req;
  logic        wr;
  gpio_reg_e   reg_idx;
  logic [31:0] rdata;
  logic [31:0] w1c_lane;
  logic [63:0] w1c64;

  logic [63:0] out_q;
  logic [63:0] oeb_q;
  logic [63:0] en_q;
  logic [63:0] mode_q;
  logic [63:0] stat_q;

  logic [63:0] out_eff;
  logic [63:0] oeb_eff;
  logic [63:0] in64;
  logic [63:0] rise64;
  logic [63:0] fall64;
  logic [63:0] ev64;

  logic [NUM_GPIO-1:0] sync_w;
  logic [NUM_GPIO-1:0] rise_w;
  logic [NUM_GPIO-1:0] fall_w;

  // Address decode; unsigned wrap makes below-base addresses fall outside
  assign off     = wbs_adr_i - BASE_ADDR;
  assign in_win  = (off < WINDOW_SIZE);
  assign req     = wbs_stb_i & wbs_cyc_i & in_win & ~wbs_ack_o;
  assign wr      = req & wbs_we_i;
  assign reg_idx = gpio_reg_e'(off[5:2]);

  // Byte-lane-qualified write data, used as the clear mask for STAT
  assign w1c_lane = byte_merge(32'h0, wbs_dat_i, wbs_sel_i);

  gpio_edge_sync #(
    .WIDTH (NUM_GPIO)
  ) u_edge_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .din  (gpio_in),
    .sync (sync_w),
    .rise (rise_w),
    .fall (fall_w)
  );

  // Widen pin-domain vectors to the 64-bit register layout and select events
  always_comb begin
    in64   = '0;
    rise64 = '0;
    fall64 = '0;
    in64[NUM_GPIO-1:0]   = sync_w;
    rise64[NUM_GPIO-1:0] = rise_w;
    fall64[NUM_GPIO-1:0] = fall_w;
    ev64 = ((rise64 & ~mode_q) | (fall64 & mode_q)) & ~RES_MASK;
  end

  // Reserved pins forced to input at the pads and on readback
  assign out_eff  = out_q & ~RES_MASK;
  assign oeb_eff  = oeb_q | RES_MASK;
  assign gpio_out = out_eff[NUM_GPIO-1:0];
  assign gpio_oeb = oeb_eff[NUM_GPIO-1:0];
  assign irq_o    = |(stat_q & en_q);

  // Write-1-to-clear mask for the addressed STAT half
  always_comb begin
    w1c64 = '0;
    if (wr && reg_idx == REG_STAT_LO) w1c64[31:0]  = w1c_lane;
    if (wr && reg_idx == REG_STAT_HI) w1c64[63:32] = w1c_lane;
  end

  // Read mux; unmapped offsets return 0
  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_OUT_LO:  rdata = out_eff[31:0];
      REG_OUT_HI:  rdata = out_eff[63:32];
      REG_OEB_LO:  rdata = oeb_eff[31:0];
      REG_OEB_HI:  rdata = oeb_eff[63:32];
      REG_IN_LO:   rdata = in64[31:0];
      REG_IN_HI:   rdata = in64[63:32];
      REG_EN_LO:   rdata = en_q[31:0];
      REG_EN_HI:   rdata = en_q[63:32];
      REG_MODE_LO: rdata = mode_q[31:0];
      REG_MODE_HI: rdata = mode_q[63:32];
      REG_STAT_LO: rdata = stat_q[31:0];
      REG_STAT_HI: rdata = stat_q[63:32];
      REG_ID:      rdata = ID_VALUE;
      default:     rdata = '0;
    endcase
  end

  // Single-cycle ack; read data is only non-zero during an acked read
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
    end
  end

  // Read/write register file, updated on the edge that acks the write
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      out_q  <= '0;
      oeb_q  <= PIN_MASK;
      en_q   <= '0;
      mode_q <= '0;
    end else if (wr) begin
      case (reg_idx)
        REG_OUT_LO:  out_q  <= word_merge(out_q,  wbs_dat_i, wbs_sel_i, 1'b0) & PIN_MASK;
        REG_OUT_HI:  out_q  <= word_merge(out_q,  wbs_dat_i, wbs_sel_i, 1'b1) & PIN_MASK;
        REG_OEB_LO:  oeb_q  <= word_merge(oeb_q,  wbs_dat_i, wbs_sel_i, 1'b0) & PIN_MASK;
        REG_OEB_HI:  oeb_q  <= word_merge(oeb_q,  wbs_dat_i, wbs_sel_i, 1'b1) & PIN_MASK;
        REG_EN_LO:   en_q   <= word_merge(en_q,   wbs_dat_i, wbs_sel_i, 1'b0) & PIN_MASK;
        REG_EN_HI:   en_q   <= word_merge(en_q,   wbs_dat_i, wbs_sel_i, 1'b1) & PIN_MASK;
        REG_MODE_LO: mode_q <= word_merge(mode_q, wbs_dat_i, wbs_sel_i, 1'b0) & PIN_MASK;
        REG_MODE_HI: mode_q <= word_merge(mode_q, wbs_dat_i, wbs_sel_i, 1'b1) & PIN_MASK;
        default: ;
      endcase
    end
  end

  // Interrupt status: a new event wins over a simultaneous clear
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      stat_q <= '0;
    end else begin
      stat_q <= ((stat_q & ~w1c64) | ev64) & PIN_MASK;
    end
  end

endmodule
